// File: rtl/div_pkg.sv
// Shared types and width constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    localparam int N_DEF = 8;
    localparam int M_DEF = 4;
    localparam int CNT_W = $clog2(N_DEF);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract divisor if it fits.
// Purely combinational; the caller registers the result.
module div_step #(
    parameter int M = 4
) (
    input  logic [M-1:0] prem_i,
    input  logic         dbit_i,
    input  logic [M-1:0] divisor_i,
    output logic [M-1:0] prem_o,
    output logic         qbit_o
);

    logic [M:0] trial;
    logic [M:0] res;
    logic       unused_res_msb;

    always_comb begin
        trial  = {prem_i, dbit_i};
        qbit_o = (trial >= {1'b0, divisor_i});
        res    = qbit_o ? (trial - {1'b0, divisor_i}) : trial;
        // The restored remainder is always below the divisor, so its top bit is zero.
        prem_o = res[M-1:0];
        unused_res_msb = res[M];
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned N/M restoring divider, one quotient bit per clk; done N+1 edges after start (1 edge on divide-by-zero).
// start is ignored while busy; with DIV_RESTART_EN defined, start during CALC aborts and restarts.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [M-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         dbz
);

    localparam int CW = (N == N_DEF) ? CNT_W : $clog2(N);

    div_state_t   state_q, state_d;
    logic [N-1:0] shift_q, shift_d;
    logic [M-1:0] prem_q, prem_d;
    logic [M-1:0] div_q, div_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0] quotient_q, quotient_d;
    logic [M-1:0] remainder_q, remainder_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         dbz_q, dbz_d;
    logic         accept;
    logic [M-1:0] step_rem;
    logic         step_bit;

    div_step #(.M(M)) u_step (
        .prem_i    (prem_q),
        .dbit_i    (shift_q[N-1]),
        .divisor_i (div_q),
        .prem_o    (step_rem),
        .qbit_o    (step_bit)
    );

    always_comb begin
`ifdef DIV_RESTART_EN
        accept = start && (state_q == IDLE || state_q == CALC);
`else
        accept = start && (state_q == IDLE);
`endif
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        prem_d      = prem_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;

        if (accept) begin
            busy_d = 1'b1;
            if (divisor == '0) begin
                // Divide-by-zero skips iteration and reports saturated results.
                state_d     = DONE;
                quotient_d  = '1;
                remainder_d = '0;
                dbz_d       = 1'b1;
                cnt_d       = '0;
            end else begin
                state_d = CALC;
                shift_d = dividend;
                prem_d  = '0;
                div_d   = divisor;
                cnt_d   = CW'(N - 1);
                dbz_d   = 1'b0;
            end
        end else begin
            case (state_q)
                CALC: begin
                    shift_d = {shift_q[N-2:0], step_bit};
                    prem_d  = step_rem;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        quotient_d  = {shift_q[N-2:0], step_bit};
                        remainder_d = step_rem;
                        state_d     = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            prem_q      <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            prem_q      <= prem_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: directed divisions, expected results and done cycles queued by the driver.
module tb_seq_restoring_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       dbz;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         at;
    } exp_t;

    exp_t exp_q[$];

    seq_restoring_divider #(.N(8), .M(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got q=%0d r=%0d dbz=%0d at cycle %0d, required no done", quotient, remainder, dbz, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (quotient !== e.q || remainder !== e.r || dbz !== e.z) begin
                    n_fail++;
                    $display("FAIL result: got q=%0d r=%0d dbz=%0d, required q=%0d r=%0d dbz=%0d", quotient, remainder, dbz, e.q, e.r, e.z);
                end
                n_checks++;
                if (cyc != e.at) begin
                    n_fail++;
                    $display("FAIL done_cycle: got %0d, required %0d", cyc, e.at);
                end
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_with_done: got %0b, required 0", busy);
                end
            end
        end
    end

    task automatic push(input logic [7:0] q, input logic [3:0] r, input logic z, input int at);
        exp_t e;
        e.q = q; e.r = r; e.z = z; e.at = at;
        exp_q.push_back(e);
    endtask

    // One-cycle start pulse; t is the cycle count before the sampling edge.
    task automatic issue(input logic [7:0] dd, input logic [3:0] dv, output int t);
        @(negedge clk);
        start = 1'b1; dividend = dd; divisor = dv;
        t = cyc;
        @(negedge clk);
        start = 1'b0; dividend = 8'($urandom); divisor = 4'($urandom);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL timeout_%s: got no done within 40 cycles, required done", name);
    endtask

    task automatic check_val(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    initial begin
        int t0;
        int t1;
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        check_val("reset_outputs", {quotient, remainder, busy, done, dbz}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'd200, 4'd7, t0);
        push(8'd28, 4'd4, 1'b0, t0 + 10);
        wait_done("200_7");

        issue(8'd255, 4'd15, t0);
        push(8'd17, 4'd0, 1'b0, t0 + 10);
        wait_done("255_15");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dividend = 8'($urandom); divisor = 4'($urandom);
            check_val("hold_quotient", int'(quotient), 17);
            check_val("hold_remainder", int'(remainder), 0);
        end

        issue(8'd5, 4'd9, t0);
        push(8'd0, 4'd5, 1'b0, t0 + 10);
        wait_done("5_9");

        issue(8'd100, 4'd0, t0);
        push(8'd255, 4'd0, 1'b1, t0 + 2);
        wait_done("100_0");
        @(negedge clk);
        check_val("dbz_held", int'(dbz), 1);

        issue(8'd12, 4'd5, t0);
        push(8'd2, 4'd2, 1'b0, t0 + 10);
        wait_done("12_5");

        // Start pulse in the middle of an iteration.
        issue(8'd200, 4'd7, t0);
`ifndef DIV_RESTART_EN
        push(8'd28, 4'd4, 1'b0, t0 + 10);
`endif
        repeat (2) @(negedge clk);
        issue(8'd50, 4'd3, t1);
`ifdef DIV_RESTART_EN
        push(8'd16, 4'd2, 1'b0, t1 + 10);
`endif
        wait_done("restart");
        repeat (12) @(negedge clk);

        // Asynchronous reset while iterating.
        issue(8'd200, 4'd7, t0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_val("async_reset_outputs", {quotient, remainder, busy, done, dbz}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_val("no_done_after_reset", exp_q.size(), 0);

        issue(8'd9, 4'd4, t0);
        push(8'd2, 4'd1, 1'b0, t0 + 10);
        wait_done("9_4");

        // start held high: back-to-back operations with one IDLE cycle between.
        @(negedge clk);
        start = 1'b1; dividend = 8'd81; divisor = 4'd9;
        t0 = cyc;
        push(8'd9, 4'd0, 1'b0, t0 + 10);
        push(8'd8, 4'd0, 1'b0, t0 + 20);
        @(negedge clk);
        dividend = 8'd64; divisor = 4'd8;
        wait_done("81_9");
        wait_done("64_8");
        start = 1'b0;
        repeat (12) @(negedge clk);

        check_val("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Iterative restoring divider: unsigned N-bit dividend divided by M-bit divisor, yielding N-bit quotient and M-bit remainder.
- Inverse companion of the team's 4x4 array multiplier; sits beside it in the arithmetic tile, driven from the same ui_in/uio_in operand pins.
- One quotient bit per clock; start/busy/done handshake toward the top-level wrapper.

Parameters:
- N, 8, dividend and quotient width.
- M, 4, divisor and remainder width (M <= N).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only per handshake rules.
- dividend  in  N  operand, captured on the accepted start edge.
- divisor  in  M  operand, captured on the accepted start edge.
- quotient  out  N  result; held stable from done until next accepted start.
- remainder  out  M  result; held stable from done until next accepted start.
- busy  out  1  high while a division is in progress.
- done  out  1  single-cycle completion pulse.
- dbz  out  1  divide-by-zero flag; valid with done, held with results.

Behaviour:
- Clock is clk. Reset rst_n is asynchronous, active-low. On reset: state IDLE, quotient=0, remainder=0, busy=0, done=0, dbz=0, iteration counter=0.
- States: IDLE, CALC, DONE.
- IDLE + start=1, divisor!=0:
  - Latch dividend into the shift register.
  - Clear partial remainder (M+1 bits).
  - Load counter=N-1, set busy=1, go to CALC.
- IDLE + start=1, divisor==0:
  - Go to DONE directly, busy=1.
  - Results: quotient=all ones, remainder=0, dbz=1.
- CALC, one step per cycle:
  - trial = {partial_rem[M-1:0], shift_reg MSB} (M+1 bits).
  - If trial >= divisor: partial_rem = trial - divisor, new quotient bit = 1.
  - Else: partial_rem = trial, new quotient bit = 0.
  - Shift the quotient bit into the shift register LSB.
  - Counter decrements. At counter==0, update quotient/remainder outputs and go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. dbz is cleared on the next accepted start.
- Latency:
  - Normal: done is high in the cycle following N CALC edges (N+1 edges after the start-sampling edge).
  - Divide-by-zero: done is high after 1 edge.
- start while busy (CALC or DONE): ignored, no effect on results (unless DIV_RESTART_EN).
- start held high continuously: a new division is accepted on the first IDLE cycle after DONE.
- Operands may change freely after the capture edge.
- Reset mid-operation: immediate return to reset values. No done pulse; partial results discarded.
- Remainder is always < divisor, so it fits in M bits. Partial remainder needs M+1 bits internally for the compare.

Optional Feature:
- Macro: DIV_RESTART_EN.
- Defined: start=1 in CALC aborts the current division. New operands are captured as if in IDLE (including the dbz fast path). No done pulse for the aborted operation; quotient/remainder outputs keep their previous values.
- Not defined: start during CALC/DONE is ignored.

Decomposition:
- Shared package div_pkg:
  - state enum (IDLE, CALC, DONE);
  - default width constants N_DEF=8, M_DEF=4;
  - counter width constant CNT_W = clog2(N).
- Sub-module div_step (combinational, one restoring iteration):
  - inputs: partial remainder, next dividend bit, divisor;
  - outputs: new partial remainder, quotient bit.
  - Instantiated once; the FSM iterates it.

Test Plan:
- Reset then 200/7 → done exactly 9 edges after start edge; quotient=28, remainder=4, dbz=0, busy low with done.
- 255/15 → quotient=17, remainder=0; then 5/9 → quotient=0, remainder=5; outputs stable between done and next start.
- 100/0 → done 1 edge after start; quotient=255, remainder=0, dbz=1; following 12/5 → quotient=2, remainder=2, dbz=0.
- start pulsed mid-CALC with 50/3 while dividing 200/7 → without DIV_RESTART_EN: result 28 r4. With DIV_RESTART_EN: 200/7 result never reported; 16 r2 reported 9 edges after the restart edge.
- rst_n asserted asynchronously mid-CALC → all outputs 0 immediately, no done; next 9/4 → quotient=2, remainder=1.
- start held high across two operations (81/9, then 64/8) → done pulses for both; quotient=9 r0, then 8 r0; one IDLE cycle between them.
